// File: rtl/bitwise_logic_pipe.sv
// bitwise_logic_pipe
//   N-bit bitwise logic unit with a registered output. It performs six plain
//   bitwise ops and has an XOR-accumulate mode that keeps a running checksum.
//   Both sides use a valid/ready handshake. Latency is one cycle, and the unit
//   can accept one beat per cycle.
//
// Parameters
//   N   operand/result width (>= 1)
//   CW  width of the accumulate beat counter (>= 1)
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   operand beat valid
//   in_ready   beat can be accepted this cycle (combinational, no skid buffer)
//   op         operation select, sampled with the beat
//   a, b       operands
//   out_valid  result valid
//   out_ready  downstream accepts result
//   f          result
//   zero       f == 0 (registered alongside f)
//   par        XOR-reduce of f (registered alongside f)
//   cnt        beats folded into the accumulator since the last ACC_CLR
//
// Op codes
//   000 AND  001 OR  010 XOR  011 XNOR  100 NAND  101 NOR
//   110 ACC_XOR  acc <= acc^a^b, result = new acc
//   111 ACC_CLR  acc <= a^b,     result = a^b
module bitwise_logic_pipe #(
  parameter int N  = 16,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    op,
  input  logic [N-1:0]  a,
  input  logic [N-1:0]  b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  f,
  output logic          zero,
  output logic          par,
  output logic [CW-1:0] cnt
);

  localparam logic [2:0] OP_AND     = 3'b000;
  localparam logic [2:0] OP_OR      = 3'b001;
  localparam logic [2:0] OP_XOR     = 3'b010;
  localparam logic [2:0] OP_XNOR    = 3'b011;
  localparam logic [2:0] OP_NAND    = 3'b100;
  localparam logic [2:0] OP_NOR     = 3'b101;
  localparam logic [2:0] OP_ACC_XOR = 3'b110;
  localparam logic [2:0] OP_ACC_CLR = 3'b111;

  logic          out_valid_reg;
  logic [N-1:0]  f_reg;
  logic          zero_reg;
  logic          par_reg;
  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] cnt_next;
  logic [N-1:0]  acc_reg;
  logic [N-1:0]  acc_next;
  logic [N-1:0]  result;
  logic          accept;
  logic          is_acc_op;

  // The output slot is free when it is empty or is being drained this cycle.
  assign in_ready  = !out_valid_reg || out_ready;
  assign accept    = in_valid && in_ready;
  assign is_acc_op = (op[2:1] == 2'b11);

  // Every op is carry-free, so the result is computed bit by bit.
  for (genvar gi = 0; gi < N; gi++) begin : g_bit
    logic res_bit;
    always_comb begin
      res_bit = 1'b0;
      case (op)
        OP_AND:     res_bit = a[gi] & b[gi];
        OP_OR:      res_bit = a[gi] | b[gi];
        OP_XOR:     res_bit = a[gi] ^ b[gi];
        OP_XNOR:    res_bit = ~(a[gi] ^ b[gi]);
        OP_NAND:    res_bit = ~(a[gi] & b[gi]);
        OP_NOR:     res_bit = ~(a[gi] | b[gi]);
        OP_ACC_XOR: res_bit = acc_reg[gi] ^ a[gi] ^ b[gi];
        OP_ACC_CLR: res_bit = a[gi] ^ b[gi];
        default:    res_bit = 1'b0;
      endcase
    end
    assign result[gi] = res_bit;
  end

  // For both accumulate ops, the new accumulator value equals the result.
  // The accumulator and counter move only on an accepted beat.
  always_comb begin
    acc_next = acc_reg;
    cnt_next = cnt_reg;
    if (accept && is_acc_op) begin
      acc_next = result;
      if (op == OP_ACC_CLR) begin
        cnt_next = CW'(1);
      end else if (cnt_reg != {CW{1'b1}}) begin
        cnt_next = cnt_reg + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      f_reg         <= '0;
      zero_reg      <= 1'b1;
      par_reg       <= 1'b0;
      cnt_reg       <= '0;
      acc_reg       <= '0;
    end else begin
      acc_reg <= acc_next;
      cnt_reg <= cnt_next;
      if (accept) begin
        out_valid_reg <= 1'b1;
        f_reg         <= result;
        zero_reg      <= ~|result;
        par_reg       <= ^result;
      end else if (out_ready) begin
        // Drained with no replacement. f and its flags keep their last value.
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign f         = f_reg;
  assign zero      = zero_reg;
  assign par       = par_reg;
  assign cnt       = cnt_reg;

endmodule

// File: tb/tb_bitwise_logic_pipe.sv
// Directed testbench for bitwise_logic_pipe.
// It drives a main instance (N=16, CW=8) and a narrow-counter instance
// (N=16, CW=2) from the same stimulus. The narrow instance is only checked
// in the saturation scenario.
module tb_bitwise_logic_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [2:0]  op;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_ready;

  logic        in_ready;
  logic        out_valid;
  logic [15:0] f;
  logic        zero;
  logic        par;
  logic [7:0]  cnt;

  logic        s_in_ready;
  logic        s_out_valid;
  logic [15:0] s_f;
  logic        s_zero;
  logic        s_par;
  logic [1:0]  s_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bitwise_logic_pipe #(.N(16), .CW(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .f(f), .zero(zero), .par(par), .cnt(cnt)
  );

  bitwise_logic_pipe #(.N(16), .CW(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .op(op), .a(a), .b(b), .out_valid(s_out_valid), .out_ready(out_ready),
    .f(s_f), .zero(s_zero), .par(s_par), .cnt(s_cnt)
  );

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_ACC_XOR = 3'b110;
  localparam logic [2:0] OP_ACC_CLR = 3'b111;

  // Expected results for ops 0..5 with a=F0F0, b=FF00.
  localparam logic [15:0] SWEEP_EXP [6] = '{16'hF000, 16'hFFF0, 16'h0FF0,
                                            16'hF00F, 16'h0FFF, 16'h000F};

  // Advance one edge. Outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] o,
                       input logic [15:0] av, input logic [15:0] bv);
    in_valid = v;
    op       = o;
    a        = av;
    b        = bv;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, OP_AND, 16'hFFFF, 16'hFFFF);
    tick();
    tick();
    $display("reset: out_valid=%0b f=%h zero=%0b par=%0b cnt=%0d", out_valid, f, zero, par, cnt);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    checks++; if (f !== 16'h0000) begin failures++; $display("FAIL reset_f got=%h exp=0000", f); end
    checks++; if (zero !== 1'b1) begin failures++; $display("FAIL reset_zero got=%0b exp=1", zero); end
    checks++; if (par !== 1'b0) begin failures++; $display("FAIL reset_par got=%0b exp=0", par); end
    checks++; if (cnt !== 8'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", cnt); end
  endtask

  task automatic test_op_sweep();
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 3'(i), 16'hF0F0, 16'hFF00);
      tick();
      $display("sweep op=%0d: f=%h out_valid=%0b zero=%0b", i, f, out_valid, zero);
      checks++; if (f !== SWEEP_EXP[i]) begin failures++; $display("FAIL sweep_f op=%0d got=%h exp=%h", i, f, SWEEP_EXP[i]); end
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL sweep_valid op=%0d got=%0b exp=1", i, out_valid); end
      checks++; if (zero !== 1'b0) begin failures++; $display("FAIL sweep_zero op=%0d got=%0b exp=0", i, zero); end
    end
    // AND of complementary patterns gives an all-zero result.
    drive(1'b1, OP_AND, 16'hF0F0, 16'h0F0F);
    tick();
    $display("sweep and-zero: f=%h zero=%0b cnt=%0d", f, zero, cnt);
    checks++; if (f !== 16'h0000) begin failures++; $display("FAIL andzero_f got=%h exp=0000", f); end
    checks++; if (zero !== 1'b1) begin failures++; $display("FAIL andzero_zero got=%0b exp=1", zero); end
    checks++; if (cnt !== 8'd0) begin failures++; $display("FAIL sweep_cnt got=%0d exp=0", cnt); end
  endtask

  task automatic test_checksum();
    logic [2:0]  ops   [3] = '{OP_ACC_CLR, OP_ACC_XOR, OP_ACC_XOR};
    logic [15:0] avals [3] = '{16'h1234, 16'h00FF, 16'h1234};
    logic [15:0] exp_f [3] = '{16'h1234, 16'h12CB, 16'h00FF};
    logic [7:0]  exp_c [3] = '{8'd1, 8'd2, 8'd3};
    logic        exp_p [3] = '{1'b1, 1'b1, 1'b0};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, ops[i], avals[i], 16'h0000);
      tick();
      $display("checksum beat %0d: f=%h cnt=%0d par=%0b", i, f, cnt, par);
      checks++; if (f !== exp_f[i]) begin failures++; $display("FAIL csum_f beat=%0d got=%h exp=%h", i, f, exp_f[i]); end
      checks++; if (cnt !== exp_c[i]) begin failures++; $display("FAIL csum_cnt beat=%0d got=%0d exp=%0d", i, cnt, exp_c[i]); end
      checks++; if (par !== exp_p[i]) begin failures++; $display("FAIL csum_par beat=%0d got=%0b exp=%0b", i, par, exp_p[i]); end
    end
  endtask

  task automatic test_backpressure();
    // Drain first so that the first stalled beat is accepted.
    drive(1'b0, OP_AND, 16'h0000, 16'h0000);
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_drain_valid got=%0b exp=0", out_valid); end
    checks++; if (f !== 16'h00FF) begin failures++; $display("FAIL bp_drain_f_hold got=%h exp=00FF", f); end
    // acc=00FF, cnt=3. Each ACC_XOR with 0F00^0001 toggles acc between 00FF and 0FFE.
    out_ready = 1'b0;
    drive(1'b1, OP_ACC_XOR, 16'h0F00, 16'h0001);
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_first got=%0b exp=1", in_ready); end
    for (int i = 0; i < 3; i++) begin
      tick();
      $display("backpressure cycle %0d: in_ready=%0b out_valid=%0b f=%h cnt=%0d", i, in_ready, out_valid, f, cnt);
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_ready cyc=%0d got=%0b exp=0", i, in_ready); end
      checks++; if (f !== 16'h0FFE) begin failures++; $display("FAIL bp_f cyc=%0d got=%h exp=0FFE", i, f); end
      checks++; if (cnt !== 8'd4) begin failures++; $display("FAIL bp_cnt cyc=%0d got=%0d exp=4", i, cnt); end
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_valid cyc=%0d got=%0b exp=1", i, out_valid); end
    end
    // Release: accept and drain happen on the same edge.
    out_ready = 1'b1;
    tick();
    $display("backpressure release: out_valid=%0b f=%h cnt=%0d", out_valid, f, cnt);
    checks++; if (f !== 16'h00FF) begin failures++; $display("FAIL bp_release_f got=%h exp=00FF", f); end
    checks++; if (cnt !== 8'd5) begin failures++; $display("FAIL bp_release_cnt got=%0d exp=5", cnt); end
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_release_valid got=%0b exp=1", out_valid); end
  endtask

  task automatic test_saturation();
    logic [1:0] exp_s [6] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, (i == 0) ? OP_ACC_CLR : OP_ACC_XOR, 16'h0001, 16'h0000);
      tick();
      $display("saturation beat %0d: cnt(CW=2)=%0d cnt(CW=8)=%0d", i, s_cnt, cnt);
      checks++; if (s_cnt !== exp_s[i]) begin failures++; $display("FAIL sat_cnt beat=%0d got=%0d exp=%0d", i, s_cnt, exp_s[i]); end
      checks++; if (cnt !== 8'(i + 1)) begin failures++; $display("FAIL wide_cnt beat=%0d got=%0d exp=%0d", i, cnt, i + 1); end
    end
  endtask

  task automatic test_mid_op_reset();
    out_ready = 1'b0;
    drive(1'b1, OP_ACC_XOR, 16'h00AA, 16'h0000);
    tick();
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL midrst_pre_valid got=%0b exp=1", out_valid); end
    rst_n = 1'b0;
    drive(1'b0, OP_AND, 16'h0000, 16'h0000);
    tick();
    $display("mid-op reset: out_valid=%0b f=%h zero=%0b cnt=%0d", out_valid, f, zero, cnt);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%0b exp=0", out_valid); end
    checks++; if (zero !== 1'b1) begin failures++; $display("FAIL midrst_zero got=%0b exp=1", zero); end
    checks++; if (cnt !== 8'd0) begin failures++; $display("FAIL midrst_cnt got=%0d exp=0", cnt); end
    rst_n = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, OP_ACC_XOR, 16'h0001, 16'h0000);
    tick();
    $display("post-reset ACC_XOR: f=%h cnt=%0d par=%0b", f, cnt, par);
    checks++; if (f !== 16'h0001) begin failures++; $display("FAIL midrst_acc_f got=%h exp=0001", f); end
    checks++; if (cnt !== 8'd1) begin failures++; $display("FAIL midrst_acc_cnt got=%0d exp=1", cnt); end
    checks++; if (par !== 1'b1) begin failures++; $display("FAIL midrst_acc_par got=%0b exp=1", par); end
  endtask

  initial begin
    rst_n = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, OP_AND, 16'h0000, 16'h0000);
    test_reset();
    test_op_sweep();
    test_checksum();
    test_backpressure();
    test_saturation();
    test_mid_op_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
